// File: rtl/bcd_result_writeback.sv
// rtl/bcd_result_writeback.sv - ADC/SBC result and N/Z/C/V flag writeback sequencer
// Optional macro BCD_WB_CMOS_FLAGS_EN: decimal-mode N/Z taken from the adjusted result.
module bcd_result_writeback #(
    parameter int DBW = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           rdy,
    input  logic           start,
    input  logic           op,
    input  logic           dec,
    input  logic [DBW-1:0] bin_o,
    input  logic           bin_co,
    input  logic           bin_v,
    input  logic [DBW-1:0] dec_o,
    input  logic           dec_co,
    output logic           busy,
    output logic           done,
    output logic           acc_we,
    output logic [DBW-1:0] acc_d,
    output logic           flag_we,
    output logic           n_o,
    output logic           z_o,
    output logic           c_o,
    output logic           v_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DADJ = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic           op_q;
    logic [DBW-1:0] bin_q;
    logic           bin_co_q;
    logic           bin_v_q;
    logic           unused_capture;

    // op and the binary carry are held for observability only; the add/sub unit
    // has already folded the operation into the carry/borrow sense.
    assign unused_capture = op_q ^ bin_co_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = dec ? DADJ : WB;
            DADJ:    state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Result and flags are loaded on the edge entering WB, so they are stable for the whole write cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q     <= 1'b0;
            bin_q    <= '0;
            bin_co_q <= 1'b0;
            bin_v_q  <= 1'b0;
            acc_d    <= '0;
            n_o      <= 1'b0;
            z_o      <= 1'b0;
            c_o      <= 1'b0;
            v_o      <= 1'b0;
        end else if (rdy) begin
            if (state == IDLE && start) begin
                op_q     <= op;
                bin_q    <= bin_o;
                bin_co_q <= bin_co;
                bin_v_q  <= bin_v;
                if (!dec) begin
                    acc_d <= bin_o;
                    c_o   <= bin_co;
                    v_o   <= bin_v;
                    n_o   <= bin_o[DBW-1];
                    z_o   <= (bin_o == '0);
                end
            end else if (state == DADJ) begin
                acc_d <= dec_o;
                c_o   <= dec_co;
                v_o   <= bin_v_q;
`ifdef BCD_WB_CMOS_FLAGS_EN
                n_o   <= dec_o[DBW-1];
                z_o   <= (dec_o == '0);
`else
                n_o   <= bin_q[DBW-1];
                z_o   <= (bin_q == '0);
`endif
            end
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == WB);
    assign acc_we  = done;
    assign flag_we = done;

endmodule

// File: tb/tb_bcd_result_writeback.sv
// tb/tb_bcd_result_writeback.sv - self-checking bench for bcd_result_writeback
module tb_bcd_result_writeback;

`ifdef BCD_WB_CMOS_FLAGS_EN
    localparam bit CMOS = 1'b1;
`else
    localparam bit CMOS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n, rdy, start, op, dec;
    logic [7:0] bin_o, dec_o;
    logic       bin_co, bin_v, dec_co;
    logic       busy, done, acc_we, flag_we;
    logic [7:0] acc_d;
    logic       n_o, z_o, c_o, v_o;

    int checks = 0;
    int failures = 0;

    logic [7:0] cur_a, cur_b;
    logic       cur_ci;
    bit         model_on = 1'b0;
    int         m_left = 0;
    bit         m_done = 1'b0;
    logic [7:0] e_acc;
    logic       e_n, e_z, e_c, e_v;

    bcd_result_writeback #(.DBW(8)) dut (
        .clk(clk), .reset_n(reset_n), .rdy(rdy), .start(start), .op(op), .dec(dec),
        .bin_o(bin_o), .bin_co(bin_co), .bin_v(bin_v), .dec_o(dec_o), .dec_co(dec_co),
        .busy(busy), .done(done), .acc_we(acc_we), .acc_d(acc_d), .flag_we(flag_we),
        .n_o(n_o), .z_o(z_o), .c_o(c_o), .v_o(v_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference 6502 add/subtract: binary result plus true decimal arithmetic on BCD operands.
    function automatic void alu(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic o,
                                output logic [7:0] bo, output logic bc, output logic bv,
                                output logic [7:0] dob, output logic dc);
        logic [8:0] t;
        logic [7:0] bb;
        int da, db, s;
        bb = o ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {8'd0, ci};
        bo = t[7:0];
        bc = t[8];
        bv = (a[7] == bb[7]) && (bo[7] != a[7]);
        da = int'(a[7:4]) * 10 + int'(a[3:0]);
        db = int'(b[7:4]) * 10 + int'(b[3:0]);
        if (!o) begin
            s  = da + db + int'(ci);
            dc = (s >= 100);
            s  = s % 100;
        end else begin
            s  = da - db - (1 - int'(ci));
            dc = (s >= 0);
            if (s < 0) s = s + 100;
        end
        dob = {4'(s / 10), 4'(s % 10)};
    endfunction

    always @(posedge clk) begin
        logic [7:0] bo, dob, nz;
        logic bc, bv, dc;
        if (!reset_n) begin
            m_left = 0;
            m_done = 1'b0;
        end else if (rdy) begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_left > 0) begin
                m_left = 0;
                m_done = 1'b1;
            end else if (start) begin
                alu(cur_a, cur_b, cur_ci, op, bo, bc, bv, dob, dc);
                e_acc = dec ? dob : bo;
                e_c   = dec ? dc : bc;
                e_v   = bv;
                nz    = (dec && CMOS) ? dob : bo;
                e_n   = nz[7];
                e_z   = (nz == 8'h00);
                if (dec) m_left = 1;
                else     m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("busy", busy, m_done || (m_left > 0));
            chk("done", done, m_done);
            chk("acc_we", acc_we, m_done);
            chk("flag_we", flag_we, m_done);
            if (m_done) begin
                chk("acc_d", acc_d, e_acc);
                chk("n_o", n_o, e_n);
                chk("z_o", z_o, e_z);
                chk("c_o", c_o, e_c);
                chk("v_o", v_o, e_v);
            end
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic o,
                          input logic d, input int stall, input bit restart,
                          input logic [7:0] lacc, input logic lc, input logic ln, input logic lz);
        logic [7:0] bo, dob;
        logic bc, bv, dc, prev;
        int first, pulses;
        alu(a, b, ci, o, bo, bc, bv, dob, dc);
        cur_a = a; cur_b = b; cur_ci = ci;
        op = o; dec = d;
        bin_o = bo; bin_co = bc; bin_v = bv; dec_o = dob; dec_co = dc;
        start = 1'b1;
        first = -1; pulses = 0; prev = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done && !prev) begin
                pulses++;
                if (first < 0) first = k;
                chk("lit_acc", acc_d, lacc);
                chk("lit_c", c_o, lc);
                chk("lit_n", n_o, ln);
                chk("lit_z", z_o, lz);
            end
            prev  = done;
            start = restart && (k < 2);
            rdy   = !(k < stall);
        end
        rdy = 1'b1;
        start = 1'b0;
        chk("latency", first, d ? 1 + stall : 0);
        chk("done_pulses", pulses, 1);
        chk("idle_after", busy, 1'b0);
    endtask

    initial begin
        logic [7:0] bo, dob;
        logic bc, bv, dc;
        reset_n = 1'b0; rdy = 1'b1; start = 1'b0; op = 1'b0; dec = 1'b0;
        bin_o = 8'h5A; bin_co = 1'b1; bin_v = 1'b1; dec_o = 8'h77; dec_co = 1'b1;
        cur_a = 8'h00; cur_b = 8'h00; cur_ci = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_we", {acc_we, flag_we}, 2'b00);
        chk("rst_acc", acc_d, 8'h00);
        chk("rst_flags", {n_o, z_o, c_o, v_o}, 4'b0000);
        reset_n = 1'b1;
        model_on = 1'b1;

        alu(8'h50, 8'h50, 1'b0, 1'b0, bo, bc, bv, dob, dc);
        chk("pin_bin_a0", {bo, bc, bv}, {8'hA0, 1'b0, 1'b1});
        alu(8'h15, 8'h27, 1'b0, 1'b0, bo, bc, bv, dob, dc);
        chk("pin_dec_42", {bo, dob, dc}, {8'h3C, 8'h42, 1'b0});
        alu(8'h99, 8'h01, 1'b0, 1'b0, bo, bc, bv, dob, dc);
        chk("pin_dec_00", {bo, dob, dc}, {8'h9A, 8'h00, 1'b1});
        alu(8'h10, 8'h01, 1'b1, 1'b1, bo, bc, bv, dob, dc);
        chk("pin_sbc_09", {bo, bc, dob, dc}, {8'h0F, 1'b1, 8'h09, 1'b1});

        run_op(8'h50, 8'h50, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b0);
        run_op(8'h15, 8'h27, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0);
        run_op(8'h99, 8'h01, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b1, !CMOS, CMOS);
        run_op(8'h10, 8'h01, 1'b1, 1'b1, 1'b1, 3, 1'b0, 8'h09, 1'b1, 1'b0, 1'b0);
        run_op(8'h15, 8'h27, 1'b0, 1'b0, 1'b1, 0, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        run_op(8'h50, 8'h50, 1'b0, 1'b0, 1'b0, 2, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        alu(8'h15, 8'h27, 1'b0, 1'b0, bo, bc, bv, dob, dc);
        cur_a = 8'h15; cur_b = 8'h27; cur_ci = 1'b0; op = 1'b0; dec = 1'b1;
        bin_o = bo; bin_co = bc; bin_v = bv; dec_o = dob; dec_co = dc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("dadj_busy", busy, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_acc", acc_d, 8'h00);
        chk("midrst_flags", {n_o, z_o, c_o, v_o}, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_nodone", {done, acc_we}, 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
